mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 85 ++++++++
 tb/tb_mem_access.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM pipeline stage: word-addressed data memory, branch-taken select and MEM/WB register.
// Optional macro MEM_MISALIGN_CHECK_EN traps accesses whose alu_result[1:0] != 0.
module mem_access #(
  parameter int DMEM_WORDS = 256,
  parameter int DMEM_AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_ctlout,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        MEM_PCSrc,
  output logic        MEM_WB_regwrite,
  output logic        MEM_WB_memtoreg,
  output logic [31:0] read_data,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  MEM_WB_rd,
  output logic        mem_misalign
);

  // NOTE: the memory array has no reset; clearing it would forbid RAM inference
  // and the stage must keep stored data across a pipeline flush.
  logic [31:0] mem [DMEM_WORDS] = '{default: '0};

  logic [DMEM_AW-1:0] word_idx;
  logic               misaligned;
  logic               do_write;
  logic               do_read;

  // Upper address bits are dropped so accesses wrap modulo DMEM_WORDS.
  assign word_idx = alu_result[DMEM_AW+1:2];

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = (memread | memwrite) & (alu_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign do_write  = memwrite & ~misaligned & ~rst;
  assign do_read   = memread & ~misaligned;
  assign MEM_PCSrc = branch & zero & ~rst;

  // NOTE: non-blocking assignments here make a same-cycle load see the
  // pre-write word, giving read-before-write without any extra logic.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[word_idx] <= rdata2out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_WB_regwrite <= 1'b0;
      MEM_WB_memtoreg <= 1'b0;
      read_data       <= '0;
      mem_alu_result  <= '0;
      MEM_WB_rd       <= '0;
    end else begin
      MEM_WB_regwrite <= wb_ctlout[1] & ~misaligned;
      MEM_WB_memtoreg <= wb_ctlout[0];
      read_data       <= do_read ? mem[word_idx] : '0;
      mem_alu_result  <= alu_result;
      MEM_WB_rd       <= five_bit_muxout;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  // Sticky until reset so software can poll it after the faulting op retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_misalign <= 1'b0;
    end else if (misaligned) begin
      mem_misalign <= 1'b1;
    end
  end
`else
  assign mem_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, then random traffic
// compared against a word-array reference model.
module tb_mem_access;

  localparam int WORDS = 256;
`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_ctlout;
  logic        branch, memread, memwrite, zero;
  logic [31:0] alu_result, rdata2out;
  logic [4:0]  five_bit_muxout;
  logic        MEM_PCSrc, MEM_WB_regwrite, MEM_WB_memtoreg, mem_misalign;
  logic [31:0] read_data, mem_alu_result;
  logic [4:0]  MEM_WB_rd;

  always #5 clk = ~clk;

  mem_access #(.DMEM_WORDS(WORDS), .DMEM_AW(8)) dut (
    .clk(clk), .rst(rst), .wb_ctlout(wb_ctlout), .branch(branch),
    .memread(memread), .memwrite(memwrite), .zero(zero),
    .alu_result(alu_result), .rdata2out(rdata2out),
    .five_bit_muxout(five_bit_muxout), .MEM_PCSrc(MEM_PCSrc),
    .MEM_WB_regwrite(MEM_WB_regwrite), .MEM_WB_memtoreg(MEM_WB_memtoreg),
    .read_data(read_data), .mem_alu_result(mem_alu_result),
    .MEM_WB_rd(MEM_WB_rd), .mem_misalign(mem_misalign)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  wb;
    logic        br, zr, rd_en, wr_en;
    logic [31:0] addr, wdata;
    logic [4:0]  dst;
    logic        exp_pc;
    logic [31:0] exp_rdata;
    logic        exp_rw, exp_mtr;
    logic [4:0]  exp_dst;
    logic        exp_mis;
  } vec_t;

  int passed = 0;
  int total  = 0;

  logic [31:0] model_mem [WORDS];
  logic        model_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else passed++;
  endtask

  function automatic bit is_bad(input logic rd_en, input logic wr_en, input logic [31:0] addr);
    return MIS_EN && (rd_en || wr_en) && (addr[1:0] != 2'b00);
  endfunction

  function automatic int idx_of(input logic [31:0] addr);
    return int'((addr / 4) % WORDS);
  endfunction

  function automatic vec_t mk(input logic r, input logic [1:0] wb, input logic br, input logic zr,
                              input logic rd_en, input logic wr_en, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] dst, input logic exp_pc,
                              input logic [31:0] exp_rdata, input logic exp_rw, input logic exp_mtr,
                              input logic [4:0] exp_dst, input logic exp_mis);
    vec_t v;
    v.rst = r; v.wb = wb; v.br = br; v.zr = zr; v.rd_en = rd_en; v.wr_en = wr_en;
    v.addr = addr; v.wdata = wdata; v.dst = dst; v.exp_pc = exp_pc;
    v.exp_rdata = exp_rdata; v.exp_rw = exp_rw; v.exp_mtr = exp_mtr;
    v.exp_dst = exp_dst; v.exp_mis = exp_mis;
    return v;
  endfunction

  // One pipeline cycle: drive, check the combinational select, clock, check MEM/WB.
  task automatic step(input vec_t v, input string tag);
    rst = v.rst; wb_ctlout = v.wb; branch = v.br; zero = v.zr;
    memread = v.rd_en; memwrite = v.wr_en; alu_result = v.addr;
    rdata2out = v.wdata; five_bit_muxout = v.dst;
    #1;
    check({tag, ".pcsrc"}, 32'(MEM_PCSrc), 32'(v.exp_pc));
    @(posedge clk);
    #1;
    check({tag, ".read_data"}, read_data, v.exp_rdata);
    check({tag, ".regwrite"}, 32'(MEM_WB_regwrite), 32'(v.exp_rw));
    check({tag, ".memtoreg"}, 32'(MEM_WB_memtoreg), 32'(v.exp_mtr));
    check({tag, ".rd"}, 32'(MEM_WB_rd), 32'(v.exp_dst));
    check({tag, ".alu"}, mem_alu_result, v.rst ? 32'h0 : v.addr);
    check({tag, ".misalign"}, 32'(mem_misalign), 32'(v.exp_mis));
    if (!v.rst && v.wr_en && !is_bad(v.rd_en, v.wr_en, v.addr))
      model_mem[idx_of(v.addr)] = v.wdata;
    model_mis = v.rst ? 1'b0 : (model_mis | is_bad(v.rd_en, v.wr_en, v.addr));
  endtask

  vec_t tbl [16];

  initial begin
    for (int i = 0; i < WORDS; i++) model_mem[i] = '0;
    model_mis = 1'b0;

    //             rst wb    br zr rd wr addr           wdata          dst    pc  rdata                              rw mtr dst    mis
    tbl[0]  = mk(1, 2'b11, 1, 1, 0, 1, 32'h0,         32'hFFFF_FFFF, 5'd5,  0, 32'h0,                             0, 0, 5'd0,  0);
    tbl[1]  = mk(1, 2'b11, 0, 0, 0, 1, 32'h0,         32'hFFFF_FFFF, 5'd5,  0, 32'h0,                             0, 0, 5'd0,  0);
    tbl[2]  = mk(0, 2'b00, 0, 0, 1, 0, 32'h0,         32'h0,         5'd0,  0, 32'h0,                             0, 0, 5'd0,  0);
    tbl[3]  = mk(0, 2'b00, 0, 0, 0, 1, 32'h10,        32'hDEAD_BEEF, 5'd0,  0, 32'h0,                             0, 0, 5'd0,  0);
    tbl[4]  = mk(0, 2'b11, 0, 0, 1, 0, 32'h10,        32'h0,         5'd8,  0, 32'hDEAD_BEEF,                     1, 1, 5'd8,  0);
    tbl[5]  = mk(0, 2'b00, 0, 0, 0, 1, 32'h404,       32'h1234_5678, 5'd0,  0, 32'h0,                             0, 0, 5'd0,  0);
    tbl[6]  = mk(0, 2'b10, 0, 0, 1, 0, 32'h004,       32'h0,         5'd9,  0, 32'h1234_5678,                     1, 0, 5'd9,  0);
    tbl[7]  = mk(0, 2'b00, 0, 0, 0, 1, 32'h20,        32'h11,        5'd0,  0, 32'h0,                             0, 0, 5'd0,  0);
    tbl[8]  = mk(0, 2'b01, 0, 0, 1, 1, 32'h20,        32'h22,        5'd4,  0, 32'h11,                            0, 1, 5'd4,  0);
    tbl[9]  = mk(0, 2'b11, 0, 0, 1, 0, 32'h20,        32'h0,         5'd4,  0, 32'h22,                            1, 1, 5'd4,  0);
    tbl[10] = mk(0, 2'b00, 1, 1, 0, 0, 32'h0,         32'h0,         5'd0,  1, 32'h0,                             0, 0, 5'd0,  0);
    tbl[11] = mk(0, 2'b00, 1, 0, 0, 0, 32'h0,         32'h0,         5'd0,  0, 32'h0,                             0, 0, 5'd0,  0);
    tbl[12] = mk(0, 2'b00, 0, 0, 0, 1, 32'h13,        32'hAA,        5'd0,  0, 32'h0,                             0, 0, 5'd0,  MIS_EN);
    tbl[13] = mk(0, 2'b11, 0, 0, 1, 0, 32'h10,        32'h0,         5'd1,  0, MIS_EN ? 32'hDEAD_BEEF : 32'hAA,   1, 1, 5'd1,  MIS_EN);
    tbl[14] = mk(1, 2'b11, 1, 1, 1, 0, 32'h10,        32'h0,         5'd3,  0, 32'h0,                             0, 0, 5'd0,  0);
    tbl[15] = mk(0, 2'b10, 0, 0, 1, 0, 32'h10,        32'h0,         5'd31, 0, MIS_EN ? 32'hDEAD_BEEF : 32'hAA,   1, 0, 5'd31, 0);

    for (int i = 0; i < 16; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Random traffic over a few hot words, with high bits set to exercise wrap-around.
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      bit   bad;
      v.rst   = ($urandom_range(0, 29) == 0);
      v.wb    = 2'($urandom_range(0, 3));
      v.br    = 1'($urandom_range(0, 1));
      v.zr    = 1'($urandom_range(0, 1));
      v.rd_en = 1'($urandom_range(0, 1));
      v.wr_en = 1'($urandom_range(0, 1));
      v.addr  = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 10)
              | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      v.wdata = $urandom;
      v.dst   = 5'($urandom_range(0, 31));
      bad         = !v.rst && is_bad(v.rd_en, v.wr_en, v.addr);
      v.exp_pc    = !v.rst && v.br && v.zr;
      v.exp_rdata = (!v.rst && v.rd_en && !bad) ? model_mem[idx_of(v.addr)] : 32'h0;
      v.exp_rw    = !v.rst && v.wb[1] && !bad;
      v.exp_mtr   = !v.rst && v.wb[0];
      v.exp_dst   = v.rst ? 5'd0 : v.dst;
      v.exp_mis   = !v.rst && (model_mis || bad);
      step(v, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
